// File: rtl/conversor_bcd_bin_2dig_pkg.sv
// Shared constants and FSM encoding for the serial 2-digit BCD to binary converter.
package conversor_bcd_bin_2dig_pkg;

    localparam int N     = 7;
    localparam int ITER  = 7;
    localparam int CNT_W = 3;

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(ITER - 1);
    localparam logic [3:0]       BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0]       ADJ_THRESH    = 4'd8;
    localparam logic [3:0]       ADJ_SUB       = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/conversor_bcd_bin_2dig_ajuste_nibble_bcd.sv
// Reverse double-dabble nibble correction: subtract 3 from any shifted digit that reaches 8.
module ajuste_nibble_bcd
    import conversor_bcd_bin_2dig_pkg::*;
(
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    assign d_out = (d_in >= ADJ_THRESH) ? (d_in - ADJ_SUB) : d_in;

endmodule

// File: rtl/conversor_bcd_bin_2dig.sv
// Serial packed-BCD (00-99) to 7-bit binary converter, one shift per clock, start/done handshake.
// Optional macro CONV_START_EDGE_EN makes start rising-edge sensitive instead of level-sensitive.
module conversor_bcd_bin_2dig
    import conversor_bcd_bin_2dig_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   bcd_in,
    output logic [N-1:0] bin_out,
    output logic         done,
    output logic         error,
    output logic         busy
);

    state_t           state_q, state_d;
    logic [7:0]       bcd_q, bcd_d;
    logic [N-1:0]     work_q, work_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_flag_q, err_flag_d;
    logic [N-1:0]     bin_q, bin_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             start_acc;

`ifdef CONV_START_EDGE_EN
    logic start_dly_q;

    always_ff @(posedge clk) begin
        if (reset) start_dly_q <= 1'b0;
        else       start_dly_q <= start;
    end

    assign start_acc = start & ~start_dly_q;
`else
    assign start_acc = start;
`endif

    // {bcd, work} shifted right by one; the BCD LSB drops into the work MSB
    logic [7:0]   shf_bcd;
    logic [N-1:0] shf_work;
    logic [3:0]   tens_adj, units_adj;

    assign shf_bcd  = {1'b0, bcd_q[7:1]};
    assign shf_work = {bcd_q[0], work_q[N-1:1]};

    ajuste_nibble_bcd u_adj_tens  (.d_in(shf_bcd[7:4]), .d_out(tens_adj));
    ajuste_nibble_bcd u_adj_units (.d_in(shf_bcd[3:0]), .d_out(units_adj));

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        bin_d      = bin_q;
        done_d     = 1'b0;
        error_d    = error_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    bcd_d      = bcd_in;
                    work_d     = '0;
                    err_flag_d = 1'b0;
                    error_d    = 1'b0;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((bcd_q[7:4] > BCD_DIGIT_MAX) || (bcd_q[3:0] > BCD_DIGIT_MAX)) begin
                    err_flag_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d  = {tens_adj, units_adj};
                work_d = shf_work;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                // error output only asserts together with done
                if (err_flag_q) error_d = 1'b1;
                else            bin_d   = work_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bcd_q      <= '0;
            work_q     <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            bin_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            bin_q      <= bin_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bin_out = bin_q;
    assign done    = done_q;
    assign error   = error_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/conversor_bcd_bin_2dig.md
Name: conversor_bcd_bin_2dig

Overview:
Converts a two-digit packed BCD value (00–99) to a 7-bit binary count. The input comes from a BCD source such as a date/time register read-back, and the output is used to preload the 2-digit up/down counters. It uses serial reverse double-dabble (shift right, then subtract-3 correction), one bit per clock, with a start/done handshake. Invalid BCD input is flagged rather than converted.

Parameters:
N, 7, binary output width; fixed at 7 (covers 0–99); other values unsupported
ITER, 7, number of shift iterations; must equal N

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
start  input  1  conversion request, sampled in IDLE only
bcd_in  input  8  packed BCD; [7:4] tens digit, [3:0] units digit; captured on accepted start
bin_out  output  N  binary result; holds last valid conversion
done  output  1  one-cycle pulse when conversion or error check completes
error  output  1  set with done if either captured nibble > 9; holds until next accepted start
busy  output  1  high in every state except IDLE

Behaviour:
- Reset values: bin_out=0, done=0, error=0, busy=0; FSM in IDLE; shift register and iteration counter cleared.
- FSM states: IDLE, CHECK, SHIFT, DONE.
- IDLE:
  - start=1 at edge E: capture bcd_in into an 8-bit BCD register, clear the 7-bit work register, clear error, go to CHECK.
  - busy rises after edge E.
- CHECK (1 cycle):
  - Either nibble > 9: set error flag, go to DONE.
  - Otherwise: counter=0, go to SHIFT.
- SHIFT (7 cycles) — each edge:
  - Shift {bcd_reg, work_reg} right by 1; the BCD LSB enters the work MSB.
  - In each shifted nibble, any value ≥ 8 has 3 subtracted.
  - counter += 1; after the 7th shift (counter==6 at the edge), go to DONE.
- DONE (1 cycle) — at the exiting edge:
  - If no error, bin_out <= work_reg.
  - done <= 1 for exactly one cycle; go to IDLE.
- Latency:
  - Valid input, start accepted at edge E: bin_out updated and done high after edge E+9.
  - Invalid input: done and error high after edge E+2; bin_out unchanged.
- Throughput: next start is accepted at edge E+10 at the earliest.
- start while busy: ignored; no queuing; bcd_in changes while busy have no effect.
- start held high: a new conversion begins each time IDLE is re-entered (level-sensitive, unless the optional feature is enabled).
- reset mid-conversion: aborts immediately; all outputs return to reset values at that edge; no done pulse.
- Arithmetic: all in 4-bit nibbles; no overflow is possible for valid BCD; the BCD register is 0 after the 7th shift for valid input.

Optional Feature:
CONV_START_EDGE_EN
- Defined: start passes through a 1-flop rising-edge detector (tick = start & ~start_d). Only a tick is accepted in IDLE, so holding start high yields a single conversion. start_d resets to 0.
- Undefined: start is level-sensitive as described above; no extra flop.

Decomposition:
- Shared package: FSM state encoding (2-bit: IDLE=0, CHECK=1, SHIFT=2, DONE=3), N=7, ITER=7, BCD_DIGIT_MAX=9, ADJ_THRESH=8, ADJ_SUB=3.
- Sub-module ajuste_nibble_bcd: combinational 4-bit in/out, returns d−3 if d≥8 else d. Instantiated twice (tens, units).

Test Plan:
- Reset, then start with bcd_in=8'h99 → busy for 9 cycles; done pulse after edge E+9; bin_out=7'd99; error=0.
- bcd_in=8'h10, then 8'h00, then 8'h07 back-to-back, each start issued at the earliest accepted edge → bin_out 10, 0, 7 respectively; each done lasts 1 cycle.
- bcd_in=8'h3A → done and error=1 after edge E+2; bin_out keeps the previous value (7); the next valid start (8'h42) → error=0, bin_out=42.
- Pulse start again during SHIFT with bcd_in=8'h55 while converting 8'h23 → the extra start is ignored; result 23; exactly one done.
- Assert reset during SHIFT of 8'h88 → bin_out=0, busy=0, no done; a subsequent start with 8'h88 → bin_out=88.
- With CONV_START_EDGE_EN defined, hold start high for 30 cycles with 8'h61 → exactly one done, bin_out=61; without the macro → 3 done pulses (every 10 cycles).
